// File: rtl/mmcm_drp_seq_if.sv
// Request-stream and DRP bus bundle between the TRNG clock controller,
// the sequencer and the MMCM primitive.
interface mmcm_drp_seq_if;
  localparam int unsigned ADDR_W = 7;
  localparam int unsigned DATA_W = 16;

  logic              req_valid;
  logic              req_ready;
  logic [ADDR_W-1:0] req_addr;
  logic [DATA_W-1:0] req_data;
  logic [DATA_W-1:0] req_mask;
  logic              req_last;

  logic              den;
  logic              dwe;
  logic [ADDR_W-1:0] daddr;
  logic [DATA_W-1:0] di;
  logic [DATA_W-1:0] drp_do;
  logic              drdy;

  // Sequencer side
  modport master (
    input  req_valid, req_addr, req_data, req_mask, req_last, drp_do, drdy,
    output req_ready, den, dwe, daddr, di
  );

  // Requester / MMCM side
  modport slave (
    output req_valid, req_addr, req_data, req_mask, req_last, drp_do, drdy,
    input  req_ready, den, dwe, daddr, di
  );
endinterface

// File: rtl/mmcm_drp_seq.sv
// MMCM reconfiguration sequencer: masked DRP read-modify-write of a list of
// registers with the MMCM held in reset, then a timed wait for lock.
module mmcm_drp_seq #(
  parameter int unsigned RST_CYCLES   = 16,
  parameter int unsigned DRDY_TIMEOUT = 64,
  parameter int unsigned LOCK_TIMEOUT = 100000
) (
  input  logic           clk,
  input  logic           rst,
  mmcm_drp_seq_if.master bus,
  output logic           mmcm_rst,
  input  logic           locked,
  output logic           busy,
  output logic           done,
  output logic           err,
  output logic           clk_ok
);
  localparam int unsigned ADDR_W = 7;
  localparam int unsigned DATA_W = 16;
  localparam int unsigned CNT_W  = 20;

  localparam logic [2:0] S_IDLE      = 3'd0;
  localparam logic [2:0] S_HOLD      = 3'd1;
  localparam logic [2:0] S_RD        = 3'd2;
  localparam logic [2:0] S_RD_WAIT   = 3'd3;
  localparam logic [2:0] S_WR        = 3'd4;
  localparam logic [2:0] S_WR_WAIT   = 3'd5;
  localparam logic [2:0] S_NEXT      = 3'd6;
  localparam logic [2:0] S_LOCK_WAIT = 3'd7;

  logic [2:0]        state, state_d;
  logic [CNT_W-1:0]  cnt, cnt_d;
  logic [ADDR_W-1:0] addr, addr_d;
  logic [DATA_W-1:0] data, data_d;
  logic [DATA_W-1:0] mask, mask_d;
  logic [DATA_W-1:0] di, di_d;
  logic              last, last_d;
  logic              req_ready, req_ready_d;
  logic              den, den_d;
  logic              dwe, dwe_d;
  logic              mmcm_rst_d, busy_d, done_d, err_d, clk_ok_d;
  logic [1:0]        lk_sync;
  logic              lk;
  logic              accept;
  logic              cnt_expired;
  logic [DATA_W-1:0] merged;

  assign lk          = lk_sync[1];
  assign accept      = bus.req_valid && req_ready;
  assign cnt_expired = (cnt <= CNT_W'(1));
  assign merged      = (bus.drp_do & mask) | (data & ~mask);

  assign bus.req_ready = req_ready;
  assign bus.den       = den;
  assign bus.dwe       = dwe;
  assign bus.daddr     = addr;
  assign bus.di        = di;

  // Next-state and next-output logic
  always_comb begin
    state_d    = state;
    cnt_d      = cnt;
    addr_d     = addr;
    data_d     = data;
    mask_d     = mask;
    last_d     = last;
    di_d       = di;
    den_d      = 1'b0;
    dwe_d      = 1'b0;
    mmcm_rst_d = mmcm_rst;
    busy_d     = busy;
    done_d     = 1'b0;
    err_d      = err;

    // req_ready is only high in IDLE/NEXT, so accept implies one of them
    if (accept) begin
      addr_d = bus.req_addr;
      data_d = bus.req_data;
      mask_d = bus.req_mask;
      last_d = bus.req_last;
    end

    unique case (state)
      S_IDLE: begin
        if (accept) begin
          err_d      = 1'b0;
          mmcm_rst_d = 1'b1;
          busy_d     = 1'b1;
          cnt_d      = CNT_W'(RST_CYCLES);
          state_d    = S_HOLD;
        end else if (clk_ok && !lk) begin
          err_d = 1'b1;
        end
      end
      S_HOLD: begin
        if (cnt == '0) begin
          den_d   = 1'b1;
          state_d = S_RD;
        end else begin
          cnt_d = cnt - CNT_W'(1);
        end
      end
      S_RD: begin
        cnt_d   = CNT_W'(DRDY_TIMEOUT);
        state_d = S_RD_WAIT;
      end
      S_RD_WAIT: begin
        if (bus.drdy) begin
          di_d    = merged;
          den_d   = 1'b1;
          dwe_d   = 1'b1;
          state_d = S_WR;
        end else if (cnt_expired) begin
          err_d      = 1'b1;
          mmcm_rst_d = 1'b0;
          busy_d     = 1'b0;
          state_d    = S_IDLE;
        end else begin
          cnt_d = cnt - CNT_W'(1);
        end
      end
      S_WR: begin
        cnt_d   = CNT_W'(DRDY_TIMEOUT);
        state_d = S_WR_WAIT;
      end
      S_WR_WAIT: begin
        if (bus.drdy) begin
          if (last) begin
            mmcm_rst_d = 1'b0;
            cnt_d      = CNT_W'(LOCK_TIMEOUT);
            state_d    = S_LOCK_WAIT;
          end else begin
            state_d = S_NEXT;
          end
        end else if (cnt_expired) begin
          err_d      = 1'b1;
          mmcm_rst_d = 1'b0;
          busy_d     = 1'b0;
          state_d    = S_IDLE;
        end else begin
          cnt_d = cnt - CNT_W'(1);
        end
      end
      S_NEXT: begin
        if (accept) begin
          den_d   = 1'b1;
          state_d = S_RD;
        end
      end
      S_LOCK_WAIT: begin
        if (lk) begin
          done_d  = 1'b1;
          busy_d  = 1'b0;
          state_d = S_IDLE;
        end else if (cnt_expired) begin
          err_d   = 1'b1;
          busy_d  = 1'b0;
          state_d = S_IDLE;
        end else begin
          cnt_d = cnt - CNT_W'(1);
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    req_ready_d = (state_d == S_IDLE) || (state_d == S_NEXT);
    clk_ok_d    = (state_d == S_IDLE) && lk && !err_d;
  end

  // State, datapath and output registers; LOCKED double-flopped into lk
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_IDLE;
      cnt       <= '0;
      addr      <= '0;
      data      <= '0;
      mask      <= '0;
      last      <= 1'b0;
      di        <= '0;
      req_ready <= 1'b0;
      den       <= 1'b0;
      dwe       <= 1'b0;
      mmcm_rst  <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      err       <= 1'b0;
      clk_ok    <= 1'b0;
      lk_sync   <= '0;
    end else begin
      state     <= state_d;
      cnt       <= cnt_d;
      addr      <= addr_d;
      data      <= data_d;
      mask      <= mask_d;
      last      <= last_d;
      di        <= di_d;
      req_ready <= req_ready_d;
      den       <= den_d;
      dwe       <= dwe_d;
      mmcm_rst  <= mmcm_rst_d;
      busy      <= busy_d;
      done      <= done_d;
      err       <= err_d;
      clk_ok    <= clk_ok_d;
      lk_sync   <= {lk_sync[0], locked};
    end
  end
endmodule

// File: doc/mmcm_drp_seq.md
# mmcm_drp_seq

Reconfiguration sequencer for the TRNG's MMCM. It accepts a stream of masked register writes, holds the MMCM in reset, and performs a DRP read-modify-write for each entry. It then releases the reset and waits for lock, with a timeout. It sits between the control logic that chooses the M/D/Q settings and the MMCM primitive's DRP/RST/LOCKED pins. It also provides a qualified clock-good flag that gates TRNG sampling.

## Interface
- Clock `CLK`; reset `RST`, synchronous, active-high.
- `RST_CYCLES`, 16: cycles MMCM_RST is held before the first DRP access (min 1, max 255).
- `DRDY_TIMEOUT`, 64: max cycles from DEN to DRDY (max 255).
- `LOCK_TIMEOUT`, 100000: max cycles from MMCM_RST release to synchronized LOCKED (max 2^20-1).
- `CLK`  in  1  system clock; also the DRP clock (DCLK).
- `RST`  in  1  synchronous active-high reset.
- `REQ_VALID`  in  1  request entry valid.
- `REQ_READY`  out  1  entry accepted when VALID&&READY.
- `REQ_ADDR`  in  7  DRP register address.
- `REQ_DATA`  in  16  new bit values.
- `REQ_MASK`  in  16  1 = keep old bit, 0 = take REQ_DATA bit.
- `REQ_LAST`  in  1  final entry of this reconfiguration.
- `MMCM_RST`  out  1  to the MMCM's RST.
- `DEN`, `DWE`  out  1 each  DRP enable and write enable.
- `DADDR`  out  7;  `DI`  out  16;  `DO`  in  16;  `DRDY`  in  1  DRP bus.
- `LOCKED`  in  1  MMCM lock, asynchronous to CLK.
- `BUSY`  out  1  sequence in progress.
- `DONE`  out  1  one-cycle pulse on successful lock.
- `ERR`  out  1  sticky failure flag.
- `CLK_OK`  out  1  MMCM output is usable.

## Operation
- LOCKED passes through a 2-flop synchronizer, giving `lk`. All decisions use `lk`.
- States: IDLE, HOLD, RD, RD_WAIT, WR, WR_WAIT, NEXT, LOCK_WAIT.
- **IDLE**
  - REQ_READY=1.
  - On handshake: latch ADDR/DATA/MASK/LAST, clear ERR, set MMCM_RST=1 and BUSY=1, load counter=RST_CYCLES, go to HOLD.
- **HOLD**
  - Decrement the counter. At 0, go to RD.
- **RD**
  - One cycle with DEN=1, DWE=0, DADDR=latched addr. Go to RD_WAIT; the timeout counter starts.
- **RD_WAIT**
  - On DRDY: capture `new = (DO & MASK) | (DATA & ~MASK)` and go to WR.
- **WR**
  - One cycle with DEN=1, DWE=1, DADDR=addr, DI=new. Go to WR_WAIT.
- **WR_WAIT**
  - On DRDY: if LAST, set MMCM_RST=0, load the lock counter, and go to LOCK_WAIT. Otherwise go to NEXT.
- **NEXT**
  - REQ_READY=1; MMCM_RST stays 1. Wait indefinitely.
  - On handshake: latch the entry and go to RD. No HOLD is repeated.
- **LOCK_WAIT**
  - On lk=1: pulse DONE, set BUSY=0, go to IDLE.
- **Timeouts**
  - DRDY_TIMEOUT cycles elapse in RD_WAIT or WR_WAIT without DRDY: set ERR, MMCM_RST=0, BUSY=0, go to IDLE. The write is not issued.
  - LOCK_TIMEOUT cycles elapse in LOCK_WAIT without lk: set ERR, BUSY=0, go to IDLE.
- **CLK_OK** = (state==IDLE) && lk && !ERR, registered.
  - If lk falls in IDLE, CLK_OK drops and ERR is set (lock loss). ERR stays set until the next accepted request.
- DRDY arriving in any state other than RD_WAIT/WR_WAIT is ignored.
- DEN is never asserted while a prior DRP access is outstanding.

## Timing
- Reset values: REQ_READY=0, MMCM_RST=0, DEN=0, DWE=0, DADDR=0, DI=0, BUSY=0, DONE=0, ERR=0, CLK_OK=0, synchronizer=0, state=IDLE. All outputs are registered.
- REQ_READY=1 on the first cycle after RST deasserts.
- First request:
  - Handshake at cycle t.
  - MMCM_RST=1 and BUSY=1 at t+1.
  - DEN (read) at t+2+RST_CYCLES.
- DRDY seen at cycle r: DEN/DWE write at r+1.
- Last write's DRDY at w: MMCM_RST=0 at w+1.
- LOCKED rising at cycle l: lk=1 at l+2; DONE pulse and CLK_OK=1 at l+3.
- Timeout: a counter loaded with N errors on the N-th cycle of waiting. ERR is set the following cycle.
- RST mid-sequence: everything returns to reset values on the next edge and MMCM_RST is released. No partial-write recovery is attempted.

## Test plan
- Single entry ADDR=0x14, DATA=0x1041, MASK=0x1000; DRP model returns DO=0xFFFF after 3 cycles; LOCKED after 50 cycles -> DI=0x1041 (bit 12 kept from DO), DONE 1 pulse, CLK_OK=1, ERR=0.
- Three entries (0x14, 0x15, 0x08) with REQ_VALID gapped 10 cycles between them -> MMCM_RST high continuously, exactly 3 reads and 3 writes, HOLD occurs once.
- DRP model never returns DRDY on the second read -> ERR=1 after DRDY_TIMEOUT, no write issued, MMCM_RST=0, back in IDLE with REQ_READY=1.
- LOCKED held 0 with LOCK_TIMEOUT=200 -> ERR=1 at cycle 201 of LOCK_WAIT, DONE never pulses, CLK_OK=0.
- After a successful lock, drop LOCKED for 1 cycle -> CLK_OK=0 and ERR=1; a new request clears ERR.
- Assert RST during WR_WAIT -> all outputs at reset values next cycle; a subsequent single-entry request completes normally.
